// File: rtl/romix_scratch_ctrl.sv
// romix_scratch_ctrl: sequences the scrypt ROMix fill and lookup loops
// around an external BlockMix core and the 1024-bit scratchpad SRAM.
module romix_scratch_ctrl #(
    parameter int N         = 1024,
    parameter int LOG2N     = 10,
    parameter int ADDR_BITS = 17
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  logic                 start,
    input  logic [1023:0]        x_in,
    output logic                 busy,
    output logic                 done,
    output logic [1023:0]        x_out,
    output logic                 mix_start,
    output logic [1023:0]        mix_in,
    input  logic                 mix_done,
    input  logic [1023:0]        mix_out,
    output logic                 scratch_read,
    output logic                 scratch_write,
    output logic [ADDR_BITS-1:0] scratch_addr,
    output logic [1023:0]        scratch_in,
    input  logic [1023:0]        scratch_out
);

    typedef enum logic [2:0] {
        IDLE,
        FILL_WR,
        FILL_MS,
        FILL_WT,
        LK_RD,
        LK_MS,
        LK_WT,
        DONE
    } state_t;

    state_t               state, state_nxt;
    logic [1023:0]        x_q, x_nxt;
    logic [1023:0]        t_q, t_nxt;
    logic [LOG2N-1:0]     idx_q, idx_nxt;
    logic [LOG2N-1:0]     j;
    logic [ADDR_BITS-1:0] addr_q, addr_nxt;
    logic                 last;

    // Integerify: low LOG2N bits of {byte65, byte64}
    always_comb begin
        j = '0;
        for (int k = 0; k < LOG2N; k++) begin
            if (k < 8) j[k] = x_q[504 + k];
            else       j[k] = x_q[488 + k];
        end
    end

    assign last = (idx_q == LOG2N'(N - 1));

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state  <= IDLE;
            x_q    <= '0;
            t_q    <= '0;
            idx_q  <= '0;
            addr_q <= '0;
        end else begin
            state  <= state_nxt;
            x_q    <= x_nxt;
            t_q    <= t_nxt;
            idx_q  <= idx_nxt;
            addr_q <= addr_nxt;
        end
    end

    always_comb begin
        state_nxt     = state;
        x_nxt         = x_q;
        t_nxt         = t_q;
        idx_nxt       = idx_q;
        addr_nxt      = addr_q;
        mix_start     = 1'b0;
        scratch_read  = 1'b0;
        scratch_write = 1'b0;
        done          = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    x_nxt     = x_in;
                    idx_nxt   = '0;
                    state_nxt = FILL_WR;
                end
            end
            FILL_WR: begin
                scratch_write = 1'b1;
                addr_nxt      = ADDR_BITS'({idx_q, 7'b0});
                state_nxt     = FILL_MS;
            end
            FILL_MS: begin
                mix_start = 1'b1;
                state_nxt = FILL_WT;
            end
            FILL_WT: begin
                if (mix_done) begin
                    x_nxt = mix_out;
                    if (last) begin
                        idx_nxt   = '0;
                        state_nxt = LK_RD;
                    end else begin
                        idx_nxt   = idx_q + LOG2N'(1);
                        state_nxt = FILL_WR;
                    end
                end
            end
            LK_RD: begin
                scratch_read = 1'b1;
                addr_nxt     = ADDR_BITS'({j, 7'b0});
                t_nxt        = x_q ^ scratch_out;
                state_nxt    = LK_MS;
            end
            LK_MS: begin
                mix_start = 1'b1;
                state_nxt = LK_WT;
            end
            LK_WT: begin
                if (mix_done) begin
                    x_nxt = mix_out;
                    if (last) begin
                        state_nxt = DONE;
                    end else begin
                        idx_nxt   = idx_q + LOG2N'(1);
                        state_nxt = LK_RD;
                    end
                end
            end
            DONE: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Address is live during a strobe and held afterwards
    assign scratch_addr = addr_nxt;
    assign scratch_in   = x_q;
    assign x_out        = x_q;
    assign busy         = (state != IDLE) && (state != DONE);

    always_comb begin
        mix_in = '0;
        unique case (state)
            FILL_WR, FILL_MS, FILL_WT: mix_in = x_q;
            LK_RD, LK_MS, LK_WT:       mix_in = t_q;
            default:                   mix_in = '0;
        endcase
    end

endmodule

// File: tb/tb_romix_scratch_ctrl.sv
// tb_romix_scratch_ctrl: directed bench for romix_scratch_ctrl at N=4
// with a bitwise-NOT BlockMix stand-in and a combinational SRAM model.
module tb_romix_scratch_ctrl;

    localparam int N     = 4;
    localparam int LOG2N = 2;
    localparam int AB    = 17;

    logic          clk;
    logic          n_rst;
    logic          start;
    logic [1023:0] x_in;
    logic          busy;
    logic          done;
    logic [1023:0] x_out;
    logic          mix_start;
    logic [1023:0] mix_in;
    logic          mix_done;
    logic [1023:0] mix_out;
    logic          scratch_read;
    logic          scratch_write;
    logic [AB-1:0] scratch_addr;
    logic [1023:0] scratch_in;
    logic [1023:0] scratch_out;

    romix_scratch_ctrl #(
        .N(N),
        .LOG2N(LOG2N),
        .ADDR_BITS(AB)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .start(start),
        .x_in(x_in),
        .busy(busy),
        .done(done),
        .x_out(x_out),
        .mix_start(mix_start),
        .mix_in(mix_in),
        .mix_done(mix_done),
        .mix_out(mix_out),
        .scratch_read(scratch_read),
        .scratch_write(scratch_write),
        .scratch_addr(scratch_addr),
        .scratch_in(scratch_in),
        .scratch_out(scratch_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [1023:0] mem [N];
    logic [AB-1:0] sa_full;
    assign sa_full = scratch_addr;
    assign scratch_out = mem[sa_full[8:7]];

    always @(posedge clk) begin
        if (scratch_write) mem[sa_full[8:7]] <= scratch_in;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int            c0;
    int            lat;
    logic          arm;
    int            n_chk;
    int            n_pass;
    int            n_fail;

    logic [AB-1:0] wr_a[$];
    logic [1023:0] wr_d[$];
    logic [AB-1:0] rd_a[$];
    logic [1023:0] ms_q[$];
    int            n_done;
    int            done_cyc;
    logic [1023:0] x_done;
    int            busy_first;
    int            busy_last;
    int            busy_cnt;
    int            excl_viol;
    int            wait_viol;
    int            stable_viol;
    logic [1023:0] cap;
    int            cnt;
    logic          waiting;

    initial begin
        mix_done = 1'b0;
        mix_out  = '0;
        waiting  = 1'b0;
        cnt      = 0;
        cap      = '0;
    end

    // recorder plus BlockMix stand-in (result = ~operand after lat cycles)
    always @(negedge clk) begin
        int rel;
        rel = cyc - c0;
        if (arm) begin
            wr_a.delete();
            wr_d.delete();
            rd_a.delete();
            ms_q.delete();
            n_done      = 0;
            done_cyc    = -1;
            x_done      = '0;
            busy_first  = -1;
            busy_last   = -1;
            busy_cnt    = 0;
            excl_viol   = 0;
            wait_viol   = 0;
            stable_viol = 0;
        end else begin
            if (scratch_write) begin
                wr_a.push_back(scratch_addr);
                wr_d.push_back(scratch_in);
            end
            if (scratch_read) rd_a.push_back(scratch_addr);
            if (mix_start) ms_q.push_back(mix_in);
            if (int'(scratch_read) + int'(scratch_write) + int'(mix_start) > 1)
                excl_viol++;
            if (busy) begin
                if (busy_first < 0) busy_first = rel;
                busy_last = rel;
                busy_cnt++;
            end
            if (done) begin
                n_done++;
                done_cyc = rel;
                x_done   = x_out;
            end
        end
        mix_done = 1'b0;
        if (!n_rst) begin
            waiting = 1'b0;
        end else if (waiting) begin
            if (scratch_read || scratch_write || mix_start) wait_viol++;
            if (mix_in !== cap) stable_viol++;
            cnt--;
            if (cnt == 0) begin
                mix_done = 1'b1;
                mix_out  = ~cap;
                waiting  = 1'b0;
            end
        end
        if (mix_start && n_rst) begin
            cap     = mix_in;
            cnt     = lat;
            waiting = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [1023:0] got,
                       input logic [1023:0] exp);
        n_chk++;
        if (got === exp) begin
            n_pass++;
        end else begin
            int w;
            w = 0;
            n_fail++;
            for (int k = 15; k >= 0; k--)
                if (got[k*64 +: 64] !== exp[k*64 +: 64]) w = k;
            $display("FAIL %s: word %0d got %h want %h",
                     tag, w, got[w*64 +: 64], exp[w*64 +: 64]);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // ROMix with NOT as BlockMix, j = low 2 bits of byte64
    function automatic logic [1023:0] golden(input logic [1023:0] xi);
        logic [1023:0] v [N];
        logic [1023:0] x;
        int            jj;
        x = xi;
        for (int i = 0; i < N; i++) begin
            v[i] = x;
            x    = ~x;
        end
        for (int i = 0; i < N; i++) begin
            jj = int'(x[505:504]);
            x  = ~(x ^ v[jj]);
        end
        return x;
    endfunction

    task automatic run(input int l, input logic [1023:0] x, input bit poke);
        lat = l;
        arm = 1'b1;
        step();
        arm   = 1'b0;
        x_in  = x;
        start = 1'b1;
        c0    = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 2000 && n_done == 0; k++) begin
            if (poke && (cyc - c0) == 5) begin
                x_in  = ~x;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            step();
        end
        start = 1'b0;
        if (n_done == 0) chk("done_timeout", 0, 1);
        if (poke) begin
            start = 1'b1;
            step();
            start = 1'b0;
        end
    endtask

    task automatic chk_zero_outputs(input string pfx);
        chk({pfx, "_busy"}, busy, 0);
        chk({pfx, "_done"}, done, 0);
        chk({pfx, "_mix_start"}, mix_start, 0);
        chk({pfx, "_rd"}, scratch_read, 0);
        chk({pfx, "_wr"}, scratch_write, 0);
        chk({pfx, "_addr"}, scratch_addr, 0);
        chk({pfx, "_x_out"}, x_out, 0);
        chk({pfx, "_mix_in"}, mix_in, 0);
        chk({pfx, "_scr_in"}, scratch_in, 0);
    endtask

    logic [1023:0] x0, x1, x2, x3, x4;

    initial begin
        n_chk  = 0;
        n_pass = 0;
        n_fail = 0;
        c0     = 0;
        lat    = 1;
        arm    = 1'b0;
        n_rst  = 1'b0;
        start  = 1'b0;
        x_in   = '0;

        x0 = {16{64'hA5C3_1E96_7B20_D84F}};
        x0[511:504] = 8'h02;
        x0[503:496] = 8'h00;
        x1 = {16{64'h1357_9BDF_0246_8ACE}};
        x1[511:504] = 8'h01;
        x1[503:496] = 8'h7E;
        x2 = {32{32'hDEAD_BEEF}};
        x3 = {16{64'hFEDC_BA98_7654_3210}};
        x4 = {16{64'h0F1E_2D3C_4B5A_6978}};

        repeat (3) step();
        chk_zero_outputs("reset");
        n_rst = 1'b1;
        step();

        // basic fill and lookup addressing, L=1
        run(1, x0, 1'b0);
        chk("t1_done_cyc", done_cyc, 25);
        chk("t1_busy_first", busy_first, 1);
        chk("t1_busy_last", busy_last, 24);
        chk("t1_busy_cnt", busy_cnt, 24);
        chk("t1_n_wr", wr_a.size(), 4);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("t1_wr_addr%0d", i), wr_a[i], i * 128);
            chk($sformatf("t1_wr_data%0d", i), wr_d[i], (i % 2) ? ~x0 : x0);
        end
        chk("t1_rd0_addr", rd_a[0], 256);
        chk("t1_rd1_addr", rd_a[1], 384);
        chk("t1_lk_mix_in0", ms_q[4], '0);
        chk("t1_x_out_hand", x_done, ~x0);
        chk("t1_x_out_model", x_done, golden(x0));
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_n_done", n_done, 1);
        chk("t1_excl", excl_viol, 0);

        // variable latency, L=5
        run(5, x1, 1'b0);
        chk("t2_done_cyc", done_cyc, 57);
        chk("t2_n_wr", wr_a.size(), 4);
        chk("t2_n_rd", rd_a.size(), 4);
        chk("t2_wait_strobe", wait_viol, 0);
        chk("t2_mix_in_stable", stable_viol, 0);
        chk("t2_excl", excl_viol, 0);
        chk("t2_x_out", x_done, golden(x1));

        // start during fill and in DONE is ignored
        run(1, x2, 1'b1);
        repeat (10) step();
        chk("t3_n_done", n_done, 1);
        chk("t3_done_cyc", done_cyc, 25);
        chk("t3_busy_after", busy, 0);
        chk("t3_n_ms", ms_q.size(), 8);
        chk("t3_x_out", x_out, golden(x2));

        // reset during LK_WT
        lat = 5;
        arm = 1'b1;
        step();
        arm   = 1'b0;
        x_in  = x3;
        start = 1'b1;
        c0    = cyc;
        step();
        start = 1'b0;
        for (int k = 0; k < 500 && rd_a.size() < 2; k++) step();
        chk("t4_reach_lk", rd_a.size(), 2);
        step();
        step();
        n_rst = 1'b0;
        step();
        chk_zero_outputs("t4_rst");
        n_rst = 1'b1;
        arm   = 1'b1;
        step();
        arm = 1'b0;
        repeat (5) step();
        chk("t4_quiet_strobes", ms_q.size() + wr_a.size() + rd_a.size(), 0);
        chk("t4_quiet_busy", busy_cnt, 0);
        run(1, x4, 1'b0);
        chk("t4_done_cyc", done_cyc, 25);
        chk("t4_n_wr", wr_a.size(), 4);
        chk("t4_x_out", x_done, golden(x4));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
